// File: rtl/calc_sequencer.sv
// calc_sequencer: button-driven sequencer for the 4-bit calculator datapath.
// Debounces two push buttons, then walks the user through
// load A -> load B -> choose op -> execute -> show result.
// It drives the operand load strobes and a registered op select.
// It also captures the ALU result and flag into display registers.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   btnNext, btnClear   raw push buttons (advance / abort to start)
//   op_in               op switches (00 Add, 01 Sub, 10 Mul, 11 Div)
//   alu_result          combinational ALU result
//   alu_status          ALU carry/borrow/overflow/div0 flag
//   loadA, loadB        one-cycle operand load strobes (combinational decode)
//   op_out              registered op select to the ALU
//   result_out          captured result for the LEDs
//   flag_out            captured status flag
//   result_valid        high while a captured result is shown
//   state_out           raw FSM state register (debug LEDs)
module calc_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnNext,
  input  logic       btnClear,
  input  logic [1:0] op_in,
  input  logic [7:0] alu_result,
  input  logic       alu_status,
  output logic       loadA,
  output logic       loadB,
  output logic [1:0] op_out,
  output logic [7:0] result_out,
  output logic       flag_out,
  output logic       result_valid,
  output logic [2:0] state_out
);

  localparam int unsigned NumBtn = 2;
  localparam int unsigned BtnNextIdx = 0;
  localparam int unsigned BtnClearIdx = 1;
  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Debounce: one identical lane per button (bit 0 = next, bit 1 = clear)
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q;
  logic [NumBtn-1:0] sync2_q;
  logic [NumBtn-1:0] level_q;
  logic [NumBtn-1:0] level_d;
  logic [NumBtn-1:0] level_prev_q;
  logic [NumBtn-1:0] press_q;
  logic [CNT_W-1:0]  cnt_q [NumBtn];
  logic [CNT_W-1:0]  cnt_d [NumBtn];

  assign btn_raw = {btnClear, btnNext};

  // Counter runs only while the synchronized sample disagrees with the level.
  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      cnt_d[i]   = '0;
      level_d[i] = level_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == LastCnt) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchronizer, debounce state and registered rising-edge press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      for (int i = 0; i < NumBtn; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  logic next_press;
  logic clear_press;
  assign next_press  = press_q[BtnNextIdx];
  assign clear_press = press_q[BtnClearIdx];

  // ---------------------------------------------------------------------------
  // Sequencer FSM and display registers
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] result_q, result_d;
  logic       flag_q, flag_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_A;
      op_q     <= 2'b00;
      result_q <= 8'h00;
      flag_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      valid_q  <= valid_d;
    end
  end

  // Strobes decode the live press pulse so the operand registers load on the
  // same edge the FSM advances; clear overrides any simultaneous next press.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    flag_d   = flag_q;
    valid_d  = valid_q;
    loadA    = 1'b0;
    loadB    = 1'b0;
    if (clear_press) begin
      state_d  = WAIT_A;
      op_d     = 2'b00;
      result_d = 8'h00;
      flag_d   = 1'b0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_A: begin
          if (next_press) begin
            loadA   = 1'b1;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (next_press) begin
            loadB   = 1'b1;
            state_d = WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (next_press) begin
            op_d    = op_in;
            state_d = EXEC;
          end
        end
        // Single-cycle execute; a next press landing here is dropped.
        EXEC: begin
          result_d = alu_result;
          flag_d   = alu_status;
          valid_d  = 1'b1;
          state_d  = SHOW;
        end
        SHOW: begin
          if (next_press) begin
            valid_d = 1'b0;
            state_d = WAIT_A;
          end
        end
        default: begin
          state_d = WAIT_A;
        end
      endcase
    end
  end

  assign op_out       = op_q;
  assign result_out   = result_q;
  assign flag_out     = flag_q;
  assign result_valid = valid_q;
  assign state_out    = 3'(state_q);

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: a small datapath model (operand registers plus
// ALU) surrounds the DUT, a reference model pushes expected output snapshots,
// and a monitor compares every change of the DUT outputs against that queue.
module tb_calc_sequencer;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnNext = 1'b0;
  logic       btnClear = 1'b0;
  logic [1:0] op_in = 2'b00;
  logic [7:0] alu_result;
  logic       alu_status;
  logic       loadA, loadB;
  logic [1:0] op_out;
  logic [7:0] result_out;
  logic       flag_out;
  logic       result_valid;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .btnNext     (btnNext),
    .btnClear    (btnClear),
    .op_in       (op_in),
    .alu_result  (alu_result),
    .alu_status  (alu_status),
    .loadA       (loadA),
    .loadB       (loadB),
    .op_out      (op_out),
    .result_out  (result_out),
    .flag_out    (flag_out),
    .result_valid(result_valid),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  // Calculator ALU: {flag, result}
  function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [7:0] r;
    logic       f;
    case (op)
      2'd0: begin r = 8'(a) + 8'(b); f = (r > 8'd15); end
      2'd1: begin r = 8'(a) - 8'(b); f = (a < b); end
      2'd2: begin r = 8'(a) * 8'(b); f = (r > 8'd15); end
      default: begin
        if (b == 4'd0) begin r = 8'h00; f = 1'b1; end
        else begin r = 8'(a / b); f = 1'b0; end
      end
    endcase
    return {f, r};
  endfunction

  // Environment datapath: operand switches and operand registers
  logic [3:0] sw = 4'd0;
  logic [3:0] reg_a = 4'd0;
  logic [3:0] reg_b = 4'd0;
  always @(posedge clk) begin
    if (loadA) reg_a <= sw;
    if (loadB) reg_b <= sw;
  end
  assign {alu_status, alu_result} = alu_fn(reg_a, reg_b, op_out);

  typedef struct packed {
    logic [2:0] st;
    logic       la;
    logic       lb;
    logic [1:0] op;
    logic [7:0] res;
    logic       fl;
    logic       rv;
  } snap_t;

  snap_t exp_q[$];

  // Reference model: sequence position plus the values the user has entered
  int         m_st = 0;
  logic [3:0] m_a = 4'd0;
  logic [3:0] m_b = 4'd0;
  logic [1:0] m_op = 2'd0;
  logic [7:0] m_res = 8'd0;
  logic       m_fl = 1'b0;
  logic       m_rv = 1'b0;
  snap_t      m_vis = '0;

  function automatic snap_t model_view();
    snap_t s;
    s.st = 3'(m_st); s.la = 1'b0; s.lb = 1'b0;
    s.op = m_op; s.res = m_res; s.fl = m_fl; s.rv = m_rv;
    return s;
  endfunction

  task automatic emit(input snap_t s);
    if (s != m_vis) exp_q.push_back(s);
    m_vis = s;
  endtask

  task automatic model_next();
    snap_t s;
    logic [8:0] r;
    case (m_st)
      0: begin s = m_vis; s.la = 1'b1; emit(s); m_a = sw; m_st = 1; emit(model_view()); end
      1: begin s = m_vis; s.lb = 1'b1; emit(s); m_b = sw; m_st = 2; emit(model_view()); end
      2: begin
        m_op = op_in; m_st = 3; emit(model_view());
        r = alu_fn(m_a, m_b, m_op);
        m_res = r[7:0]; m_fl = r[8]; m_rv = 1'b1; m_st = 4; emit(model_view());
      end
      default: begin m_rv = 1'b0; m_st = 0; emit(model_view()); end
    endcase
  endtask

  task automatic model_clear();
    m_st = 0; m_op = 2'd0; m_res = 8'd0; m_fl = 1'b0; m_rv = 1'b0;
    emit(model_view());
  endtask

  // Monitor: every change of the visible outputs must match the queue head
  snap_t prev_s = '0;
  snap_t cur_s;
  snap_t exp_s;
  always @(negedge clk) begin
    cur_s = {state_out, loadA, loadB, op_out, result_out, flag_out, result_valid};
    if (cur_s !== prev_s) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got st=%0d la=%b lb=%b op=%0d res=%h fl=%b rv=%b, required no change",
                 cur_s.st, cur_s.la, cur_s.lb, cur_s.op, cur_s.res, cur_s.fl, cur_s.rv);
      end else begin
        exp_s = exp_q.pop_front();
        if (cur_s !== exp_s) begin
          errors++;
          $display("FAIL scoreboard: got st=%0d la=%b lb=%b op=%0d res=%h fl=%b rv=%b, required st=%0d la=%b lb=%b op=%0d res=%h fl=%b rv=%b",
                   cur_s.st, cur_s.la, cur_s.lb, cur_s.op, cur_s.res, cur_s.fl, cur_s.rv,
                   exp_s.st, exp_s.la, exp_s.lb, exp_s.op, exp_s.res, exp_s.fl, exp_s.rv);
        end
      end
      prev_s = cur_s;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Hold the given buttons for 'hold' sampling edges, then release and settle.
  task automatic press(input logic n, input logic c, input int hold);
    if (hold >= int'(D)) begin
      if (c) model_clear();
      else if (n) model_next();
    end
    @(posedge clk); #2;
    btnNext = n; btnClear = c;
    repeat (hold) @(posedge clk);
    #2;
    btnNext = 1'b0; btnClear = 1'b0;
    repeat (D + 10) @(posedge clk);
  endtask

  int la_cnt;
  int la_at;
  logic [2:0] st7;

  initial begin
    #1 rst = 1'b1;
    #20;
    check("reset_state", 32'(state_out), 0);
    check("reset_outputs", 32'({loadA, loadB, op_out, result_out, flag_out, result_valid}), 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Glitch shorter than the debounce window: no pulse
    press(1'b1, 1'b0, 3);
    check("glitch_state", 32'(state_out), 0);

    // Press latency: strobe visible D+2 edges after the first high sample,
    // state advances on edge D+3
    sw = 4'd5;
    model_next();
    la_cnt = 0; la_at = -1; st7 = 3'd0;
    @(posedge clk); #2 btnNext = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (loadA) begin la_cnt++; la_at = k; end
      if (k == 7) st7 = state_out;
      if (k == 9) btnNext = 1'b0;
    end
    repeat (D + 10) @(posedge clk);
    check("loadA_count", 32'(la_cnt), 1);
    check("loadA_latency", 32'(la_at), 6);
    check("state_after_press", 32'(st7), 1);

    // Full add sequence: 5 + 7
    sw = 4'd7; press(1'b1, 1'b0, 6);
    op_in = 2'b00; press(1'b1, 1'b0, 6);
    check("add_result", 32'(result_out), 32'h0C);
    check("add_flag", 32'(flag_out), 0);
    check("add_valid", 32'(result_valid), 1);
    check("add_state", 32'(state_out), 4);

    // SHOW exit keeps the result
    press(1'b1, 1'b0, 6);
    check("show_exit_state", 32'(state_out), 0);
    check("show_exit_valid", 32'(result_valid), 0);
    check("show_exit_result", 32'(result_out), 32'h0C);

    // Divide by zero, then op switches change while showing
    sw = 4'd9; press(1'b1, 1'b0, 6);
    sw = 4'd0; press(1'b1, 1'b0, 6);
    op_in = 2'b11; press(1'b1, 1'b0, 6);
    check("div0_flag", 32'(flag_out), 1);
    op_in = 2'b00;
    repeat (10) @(posedge clk);
    check("op_held", 32'(op_out), 3);
    press(1'b1, 1'b0, 6);

    // Clear in WAIT_OP
    sw = 4'd3; press(1'b1, 1'b0, 6);
    sw = 4'd2; press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    check("clear_state", 32'(state_out), 0);
    check("clear_result", 32'(result_out), 0);
    check("clear_valid", 32'(result_valid), 0);

    // Clear and next together from WAIT_B
    sw = 4'd4; press(1'b1, 1'b0, 6);
    press(1'b1, 1'b1, 6);
    check("both_state", 32'(state_out), 0);

    // Async reset between edges while in WAIT_B
    press(1'b1, 1'b0, 6);
    @(posedge clk); #3 rst = 1'b1;
    m_st = 0; m_op = 2'd0; m_res = 8'd0; m_fl = 1'b0; m_rv = 1'b0;
    emit(model_view());
    #1;
    check("async_rst_state", 32'(state_out), 0);
    check("async_rst_outputs", 32'({loadA, loadB, op_out, result_out, flag_out, result_valid}), 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    sw = 4'd6; press(1'b1, 1'b0, 6);
    check("restart_state", 32'(state_out), 1);

    // Randomized button traffic
    for (int i = 0; i < 70; i++) begin
      int act;
      sw = 4'($urandom_range(0, 15));
      op_in = 2'($urandom_range(0, 3));
      act = int'($urandom_range(0, 9));
      if (act <= 5)      press(1'b1, 1'b0, int'($urandom_range(D, D + 4)));
      else if (act == 6) press(1'b0, 1'b1, int'($urandom_range(D, D + 4)));
      else if (act == 7) press(1'b1, 1'b1, int'($urandom_range(D, D + 4)));
      else if (act == 8) press(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, D - 1)));
      else               repeat (5) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
